// File: rtl/french_pkg.sv
// Shared types and helpers for the french enemy step scheduler and mover.
package french_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } sched_state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Direction code map shared with the mover: code[3:2] selects the direction.
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_RIGHT = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  function automatic dir_t dir_of(input logic [3:0] code);
    return dir_t'(code[3:2]);
  endfunction

  // Frames per step, clamped so higher levels never reach a zero or negative period.
  function automatic logic signed [5:0] calc_period(input int base, input int step,
                                                    input logic [1:0] level);
    int p;
    p = base - int'(level) * step;
    if (p < 1) p = 1;
    return 6'(p);
  endfunction

endpackage

// File: rtl/french_step_scheduler_lfsr16.sv
// 16-bit Galois LFSR, free-running every clock; recovers from the all-zero lock-up state.
module lfsr16
  import french_pkg::*;
(
  input  logic        CLK,
  input  logic        RESETn,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_q, q_d;

  always_comb begin
    if (q_q == 16'h0) begin
      q_d = seed;
    end else begin
      q_d = {1'b0, q_q[15:1]} ^ (q_q[0] ? LFSR_TAPS : 16'h0);
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      q_q <= seed;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/french_step_scheduler.sv
// Paces the french enemy mover: frame-counted step strobe, random direction code, freeze window.
module french_step_scheduler
  import french_pkg::*;
#(
  parameter logic [15:0] SEED          = 16'hACE1,
  parameter int unsigned BASE_PERIOD   = 8,
  parameter int unsigned LEVEL_STEP    = 2,
  parameter int unsigned FREEZE_FRAMES = 30
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       startOfFrame,
  input  logic       enable,
  input  logic       freeze,
  input  logic [1:0] level,
  output logic       timer_done,
  output logic [3:0] random,
  output logic       frozen
);

  localparam logic [4:0] FreezeLast = 5'(FREEZE_FRAMES - 1);

  sched_state_t      state_q, state_d;
  logic [4:0]        frame_cnt_q, frame_cnt_d;
  logic [4:0]        frz_cnt_q, frz_cnt_d;
  logic              timer_done_q, timer_done_d;
  logic [3:0]        random_q, random_d;
  logic              frozen_q, frozen_d;
  logic [15:0]       lfsr_q;
  logic signed [5:0] period;
  logic              at_period;
  logic              unused_lfsr;

  lfsr16 u_lfsr (
    .CLK    (CLK),
    .RESETn (RESETn),
    .seed   (SEED),
    .q      (lfsr_q)
  );

  assign unused_lfsr = ^lfsr_q[15:4];

  always_comb begin
    period    = calc_period(int'(BASE_PERIOD), int'(LEVEL_STEP), level);
    // >= rather than == so a level raise fires on the next frame instead of wrapping.
    at_period = $signed({1'b0, frame_cnt_q}) >= (period - 6'sd1);

    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    frz_cnt_d    = frz_cnt_q;
    timer_done_d = 1'b0;

    if (!enable) begin
      state_d     = IDLE;
      frame_cnt_d = '0;
      frz_cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: state_d = RUN;
        RUN: begin
          if (freeze) begin
            state_d   = FROZEN;
            frz_cnt_d = '0;
          end else if (startOfFrame) begin
            if (at_period) begin
              timer_done_d = 1'b1;
              frame_cnt_d  = '0;
            end else begin
              frame_cnt_d = frame_cnt_q + 5'd1;
            end
          end
        end
        FROZEN: begin
          if (startOfFrame && (frz_cnt_q == FreezeLast)) begin
            state_d   = RUN;
            frz_cnt_d = '0;
          end else if (freeze) begin
            frz_cnt_d = '0;
          end else if (startOfFrame) begin
            frz_cnt_d = frz_cnt_q + 5'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    random_d = timer_done_d ? lfsr_q[3:0] : random_q;
    frozen_d = (state_d == FROZEN);
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q      <= IDLE;
      frame_cnt_q  <= '0;
      frz_cnt_q    <= '0;
      timer_done_q <= 1'b0;
      random_q     <= '0;
      frozen_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      frz_cnt_q    <= frz_cnt_d;
      timer_done_q <= timer_done_d;
      random_q     <= random_d;
      frozen_q     <= frozen_d;
    end
  end

  assign timer_done = timer_done_q;
  assign random     = random_q;
  assign frozen     = frozen_q;

endmodule
